// File: rtl/nem_mux_ctrl_pkg.sv
// Shared definitions for the NEM one-hot mux select controller: state encoding,
// default sizing and the width helpers used by the controller and its arbiter.
package nem_mux_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAKE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_BREAK  = 2'd3
    } state_e;

    localparam int NUM_IN_DEF     = 4;
    localparam int SETTLE_CYC_DEF = 8;
    localparam int DEAD_CYC_DEF   = 4;

    // One down-counter serves both MAKE and BREAK, so it must hold the larger load.
    function automatic int cnt_width(input int settle, input int dead);
        int max_load;
        max_load = (settle > dead) ? settle : dead;
        return $clog2(max_load + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nem_rr_arb.sv
// Combinational round-robin picker: searches upward from last_granted+1 with
// wrap and returns the first requesting index as a one-hot vector.
module nem_rr_arb
    import nem_mux_ctrl_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    localparam int IDX_W = idx_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  last_granted,
    output logic [NUM_IN-1:0] winner
);

    logic             found;
    logic [IDX_W-1:0] pos;
    int               idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        idx    = 0;
        for (int off = 1; off <= NUM_IN; off++) begin
            idx = int'(last_granted) + off;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            pos = IDX_W'(idx);
            if (!found && req[pos]) begin
                winner[pos] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make select controller for a NEM relay one-hot mux: arbitrates,
// waits for relay pull-in before granting, and enforces a dead time between routes.
module nem_ohmux_sel_ctrl
    import nem_mux_ctrl_pkg::*;
#(
    parameter int NUM_IN     = NUM_IN_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int DEAD_CYC   = DEAD_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    output logic [NUM_IN-1:0] S,
    output logic [NUM_IN-1:0] gnt,
    output logic              route_valid,
    output logic              busy
);

    localparam int IDX_W = idx_width(NUM_IN);
    localparam int CNT_W = cnt_width(SETTLE_CYC, DEAD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_DEAD   = CNT_W'(DEAD_CYC);

    state_e              state_q;
    logic [NUM_IN-1:0]   s_q;
    logic [NUM_IN-1:0]   gnt_q;
    logic                rv_q;
    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    last_q;
    logic [IDX_W-1:0]    win_q;

    logic [NUM_IN-1:0]   arb_winner;
    logic [IDX_W-1:0]    idx_terms [NUM_IN];
    logic [IDX_W-1:0]    arb_idx;
    logic                win_req;

    nem_rr_arb #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .req          (req),
        .last_granted (last_q),
        .winner       (arb_winner)
    );

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_enc
        assign idx_terms[gi] = arb_winner[gi] ? IDX_W'(gi) : '0;
    end

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            arb_idx = arb_idx | idx_terms[i];
        end
    end

    // While a route is held, S is exactly the winner's one-hot, so it doubles as the mask.
    assign win_req = |(req & s_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            gnt_q   <= '0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= IDX_W'(NUM_IN - 1);
            win_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_MAKE;
                        s_q     <= arb_winner;
                        win_q   <= arb_idx;
                        cnt_q   <= CNT_SETTLE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_MAKE: begin
                    if (!win_req) begin
                        state_q <= ST_BREAK;
                        s_q     <= '0;
                        cnt_q   <= CNT_DEAD;
                    end else if (cnt_q == CNT_ONE) begin
                        state_q <= ST_ACTIVE;
                        gnt_q   <= s_q;
                        rv_q    <= 1'b1;
                        last_q  <= win_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (!win_req) begin
                        state_q <= ST_BREAK;
                        s_q     <= '0;
                        gnt_q   <= '0;
                        rv_q    <= 1'b0;
                        cnt_q   <= CNT_DEAD;
                    end
                end
                ST_BREAK: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    s_q     <= '0;
                    gnt_q   <= '0;
                    rv_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign S           = s_q;
    assign gnt         = gnt_q;
    assign route_valid = rv_q;
    assign busy        = busy_q;

endmodule

// File: doc/nem_ohmux_sel_ctrl.md
NEM_OHMUX_SEL_CTRL -- requirements
Module: nem_ohmux_sel_ctrl

Interface
REQ-001 Parameters SHALL be (one per line):
- NUM_IN, default 4: number of requesters and select lines.
- SETTLE_CYC, default 8: relay pull-in settle cycles (must be >= 1).
- DEAD_CYC, default 4: break-before-make dead cycles (must be >= 1).
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (one per line):
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, NUM_IN: level request per requester; held high for the whole use of the mux.
- S, output, NUM_IN: one-hot-or-zero select, driving S0..S3 of the 4-input, 8-bit NEM one-hot inverting mux.
- gnt, output, NUM_IN: one-hot-or-zero grant; high only while the route is settled.
- route_valid, output, 1: OR of gnt; the mux ZN output is usable.
- busy, output, 1: high in any state other than IDLE.

Function
REQ-004 FSM states SHALL be IDLE, MAKE, ACTIVE and BREAK.
REQ-005 All outputs SHALL be registered.
REQ-006 IDLE with req == 0: the block SHALL stay in IDLE with S = 0.
REQ-007 IDLE with any req bit high sampled at edge k: the block SHALL pick a winner w by round-robin, go to MAKE, and drive S = onehot(w) after edge k.
REQ-008 Round-robin SHALL search from index (last_granted + 1) mod NUM_IN upward with wrap. last_granted resets to NUM_IN-1, so index 0 has first priority.
REQ-009 MAKE SHALL count SETTLE_CYC edges, then enter ACTIVE. gnt[w] and route_valid SHALL go high after edge k+SETTLE_CYC, and last_granted SHALL update to w on that edge.
REQ-010 If req[w] is low at any edge in MAKE, the block SHALL abort to BREAK with no grant issued and last_granted unchanged.
REQ-011 ACTIVE SHALL hold S, gnt and route_valid while req[w] is high. Changes on other req bits SHALL be ignored, with no preemption.
REQ-012 If req[w] is low at edge m in ACTIVE, then after edge m: S = 0, gnt = 0, route_valid = 0, and the state is BREAK.
REQ-013 BREAK SHALL hold S = 0 for DEAD_CYC edges, then go to IDLE.
REQ-014 The earliest next nonzero S SHALL appear after edge m+DEAD_CYC+1.
REQ-015 At no cycle SHALL S have more than one bit set.
REQ-016 No cycle SHALL contain a direct transition of S between two different nonzero values.
REQ-017 gnt SHALL always equal S or 0, never another bit.
REQ-018 A single counter of width $clog2(max(SETTLE_CYC, DEAD_CYC)+1) SHALL be shared by MAKE and BREAK, loaded on state entry and counting down to 1.
REQ-019 Simultaneous requests at IDLE SHALL resolve by round-robin only; no requester SHALL wait more than NUM_IN-1 grants.

Reset
REQ-020 rst high at an edge SHALL force IDLE, S = 0, gnt = 0, route_valid = 0, busy = 0, counter = 0 and last_granted = NUM_IN-1, regardless of state, including mid-MAKE or mid-ACTIVE.
REQ-021 rst SHALL take priority over every transition; the first arbitration SHALL occur at the first edge with rst low.

Structure
REQ-022 State encoding, NUM_IN/SETTLE_CYC/DEAD_CYC defaults and the counter-width function SHALL live in shared package nem_mux_ctrl_pkg.
REQ-023 Round-robin selection SHALL be one sub-module, nem_rr_arb (req, last_granted -> onehot winner, combinational); everything else SHALL be in nem_ohmux_sel_ctrl.

Verification (NUM_IN=4, SETTLE_CYC=8, DEAD_CYC=4)
REQ-024 After reset, req=0001 at edge 0:
- S=0001 after edge 0.
- gnt=0001 and route_valid=1 after edge 8.
- Drop req at edge 20 -> S=0 after edge 20, busy=0 after edge 24.
REQ-025 req=1111 held, each grantee dropping 3 edges after its grant -> grant order 0,1,2,3,0. Each S change SHALL be separated by >= 4 cycles of S=0.
REQ-026 req=0100 at edge 0, dropped at edge 3 (mid-MAKE) -> gnt never asserts, S=0 after edge 3, IDLE after edge 7, last_granted still 3.
REQ-027 Granted on 0; req[2] rises while ACTIVE -> no change to S or gnt until req[0] drops. Then S=0100 appears exactly 5 edges after the drop.
REQ-028 rst pulsed at edge 5 of MAKE and again in ACTIVE -> all outputs 0 after that edge. Next arbitration restarts from index 0.
REQ-029 A concurrent assertion checker SHALL run on all tests: S onehot0, gnt subset of S, route_valid == |gnt, and no nonzero-to-nonzero S change.
